// File: rtl/au_hs_if.sv
// Valid/ready request and response bundle for the au_hs arithmetic unit.
interface au_hs_if #(
    parameter int W = 24
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ovf;
    logic         dz;
    logic         busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, ovf, dz, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, ovf, dz, busy
    );
endinterface

// File: rtl/au_hs.sv
// Handshaked saturating sign-magnitude Q(M).FRAC unit: 1-cycle ADD/SUB/MUL, restoring DIV.
// Define AU_ROUND_EN for round-half-up on MUL and DIV (DIV then takes one extra cycle).
module au_hs #(
    parameter int W    = 24,
    parameter int FRAC = 14
) (
    input logic    clk,
    input logic    rst,
    au_hs_if.slave bus
);
    localparam int MW  = W - 1;
    localparam int M   = W - 1 - FRAC;
    localparam int MQW = 2 * MW - FRAC + 1;
`ifdef AU_ROUND_EN
    localparam int QW  = W;
`else
    localparam int QW  = W - 1;
`endif
    localparam int CW  = $clog2(QW);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

    state_t          state, state_next;
    logic            accept, start_div, div_sat;
    logic [MW-1:0]   mag_a, mag_b;
    logic            sign_a, sign_b;
    logic [MW:0]     add_sum;
    logic            add_sign;
    logic [2*MW-1:0] prod;
    logic [MQW-1:0]  mul_q;
    logic [MW-1:0]   fast_mag;
    logic            fast_sign, fast_ovf, fast_dz;

    logic [CW-1:0]   cnt;
    logic [MW-1:0]   rem, rem_next, div_b;
    logic [QW-1:0]   dsr, quot;
    logic [MW:0]     trial;
    logic            q_bit, div_sign, div_ovf;
    logic [MW-1:0]   div_mag;

    logic [W-1:0]    result;
    logic            ovf, dz;

    assign bus.in_ready  = (state != DIV) && (!bus.out_valid || bus.out_ready);
    assign bus.out_valid = (state == HOLD);
    assign bus.busy      = (state == DIV);
    assign bus.result    = result;
    assign bus.ovf       = ovf;
    assign bus.dz        = dz;

    assign accept = bus.in_valid && bus.in_ready;

    assign mag_a  = bus.a[MW-1:0];
    assign mag_b  = bus.b[MW-1:0];
    assign sign_a = bus.a[W-1];
    assign sign_b = bus.b[W-1] ^ (bus.op == OP_SUB);

    // Quotient fits in the magnitude only while |a| < |b| << M.
    assign div_sat   = {{M{1'b0}}, mag_a} >= {mag_b, {M{1'b0}}};
    assign start_div = accept && (bus.op == OP_DIV) && (mag_b != '0) && !div_sat;

    assign prod = mag_a * mag_b;
`ifdef AU_ROUND_EN
    assign mul_q = MQW'(prod >> FRAC) + MQW'(prod[FRAC-1]);
`else
    assign mul_q = MQW'(prod >> FRAC);
`endif

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        add_sum  = '0;
        add_sign = sign_a;
        if (sign_a == sign_b) begin
            add_sum = {1'b0, mag_a} + {1'b0, mag_b};
        end else if (mag_a >= mag_b) begin
            add_sum = {1'b0, mag_a - mag_b};
        end else begin
            add_sum  = {1'b0, mag_b - mag_a};
            add_sign = sign_b;
        end
    end

    always_comb begin
        fast_sign = 1'b0;
        fast_mag  = '0;
        fast_ovf  = 1'b0;
        fast_dz   = 1'b0;
        case (bus.op)
            OP_ADD, OP_SUB: begin
                fast_sign = add_sign;
                fast_ovf  = add_sum[MW];
                fast_mag  = add_sum[MW] ? '1 : add_sum[MW-1:0];
            end
            OP_MUL: begin
                fast_sign = sign_a ^ sign_b;
                fast_ovf  = |mul_q[MQW-1:MW];
                fast_mag  = fast_ovf ? '1 : mul_q[MW-1:0];
            end
            default: begin
                // Only divide-by-zero and quotient overflow finish in one cycle.
                fast_sign = sign_a ^ sign_b;
                fast_mag  = '1;
                fast_dz   = (mag_b == '0);
                fast_ovf  = (mag_b != '0);
            end
        endcase
        if (fast_mag == '0) fast_sign = 1'b0;
    end

    // One restoring step: dividend bits shift out of dsr's top as quotient bits shift in.
    assign trial    = {rem, dsr[QW-1]};
    assign q_bit    = trial >= {1'b0, div_b};
    assign rem_next = q_bit ? MW'(trial - {1'b0, div_b}) : trial[MW-1:0];
    assign quot     = {dsr[QW-2:0], q_bit};

`ifdef AU_ROUND_EN
    logic [MW:0] div_round;
    assign div_round = {1'b0, quot[QW-1:1]} + {{MW{1'b0}}, quot[0]};
    assign div_ovf   = div_round[MW];
    assign div_mag   = div_ovf ? '1 : div_round[MW-1:0];
`else
    assign div_ovf   = 1'b0;
    assign div_mag   = quot;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE, HOLD: begin
                if (accept)                              state_next = start_div ? DIV : HOLD;
                else if (state == HOLD && bus.out_ready) state_next = IDLE;
            end
            DIV:     if (cnt == '0) state_next = HOLD;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            ovf      <= 1'b0;
            dz       <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            dsr      <= '0;
            div_b    <= '0;
            div_sign <= 1'b0;
        end else if (accept) begin
            if (start_div) begin
                cnt      <= CW'(QW - 1);
                rem      <= mag_a >> M;
                dsr      <= {mag_a[M-1:0], {(QW-M){1'b0}}};
                div_b    <= mag_b;
                div_sign <= sign_a ^ sign_b;
            end else begin
                result <= {fast_sign, fast_mag};
                ovf    <= fast_ovf;
                dz     <= fast_dz;
            end
        end else if (state == DIV) begin
            rem <= rem_next;
            dsr <= quot;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                result <= {div_sign && (div_mag != '0), div_mag};
                ovf    <= div_ovf;
                dz     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_au_hs.sv
// Directed self-checking bench for au_hs: arithmetic, saturation, DIV timing, back-pressure, reset abort.
module tb_au_hs;
    localparam int W    = 24;
    localparam int FRAC = 14;
`ifdef AU_ROUND_EN
    localparam int DIV_LAT = W + 1;
`else
    localparam int DIV_LAT = W;
`endif
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    au_hs_if #(.W(W)) bus ();

    au_hs #(.W(W), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Issue one request at a negedge, scramble inputs afterwards, and time the response.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [W-1:0] exp_res,
                          input logic exp_ovf, input logic exp_dz, input int exp_lat);
        int lat;
        int busy_n;
        int nrdy_n;
        lat    = 0;
        busy_n = 0;
        nrdy_n = 0;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.a        = va;
        bus.b        = vb;
        for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.op       = 2'($urandom);
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            if (bus.out_valid) begin
                lat = cyc;
            end else begin
                busy_n += int'(bus.busy);
                nrdy_n += int'(!bus.in_ready);
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        check({tag, ".stall_cycles"}, 32'(nrdy_n), 32'(exp_lat - 1));
        check({tag, ".result"}, 32'(bus.result), 32'(exp_res));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        check({tag, ".dz"}, 32'(bus.dz), 32'(exp_dz));
    endtask

    logic [W-1:0] s_a   [4] = '{24'h004000, 24'h008000, 24'h00C000, 24'h804000};
    logic [W-1:0] s_b   [4] = '{24'h004000, 24'h004000, 24'h804000, 24'h804000};
    logic [W-1:0] s_exp [4] = '{24'h008000, 24'h00C000, 24'h008000, 24'h808000};

    initial begin
        int stray;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.result", 32'(bus.result), 32'd0);
        check("reset.ovf", 32'(bus.ovf), 32'd0);
        check("reset.dz", 32'(bus.dz), 32'd0);
        check("reset.busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // Add/sub: mixed signs, cancellation to +0, carry saturation both signs.
        run_op("add_2_m3",   OP_ADD, 24'h008000, 24'h80C000, 24'h804000, 1'b0, 1'b0, 1);
        run_op("sub_5_5",    OP_SUB, 24'h014000, 24'h014000, 24'h000000, 1'b0, 1'b0, 1);
        run_op("add_sat_p",  OP_ADD, 24'h4B0000, 24'h4B0000, 24'h7FFFFF, 1'b1, 1'b0, 1);
        run_op("sub_sat_n",  OP_SUB, 24'hCB0000, 24'h4B0000, 24'hFFFFFF, 1'b1, 1'b0, 1);

        // Multiply: signs, zero product forced to +0, overflow.
        run_op("mul_15_25",  OP_MUL, 24'h006000, 24'h00A000, 24'h00F000, 1'b0, 1'b0, 1);
        run_op("mul_m15_25", OP_MUL, 24'h806000, 24'h00A000, 24'h80F000, 1'b0, 1'b0, 1);
        run_op("mul_zero",   OP_MUL, 24'h806000, 24'h000000, 24'h000000, 1'b0, 1'b0, 1);
        run_op("mul_400_2",  OP_MUL, 24'h640000, 24'h008000, 24'h7FFFFF, 1'b1, 1'b0, 1);

        // Divide: iterative cases, then the one-cycle exceptions.
        run_op("div_1_2",    OP_DIV, 24'h004000, 24'h008000, 24'h002000, 1'b0, 1'b0, DIV_LAT);
        run_op("div_m4_2",   OP_DIV, 24'h810000, 24'h008000, 24'h808000, 1'b0, 1'b0, DIV_LAT);
        run_op("div_1_3",    OP_DIV, 24'h004000, 24'h00C000, 24'h001555, 1'b0, 1'b0, DIV_LAT);
        run_op("div_edge",   OP_DIV, 24'h3FFFFF, 24'h002000, 24'h7FFFFE, 1'b0, 1'b0, DIV_LAT);
        run_op("div_m0",     OP_DIV, 24'h800000, 24'h004000, 24'h000000, 1'b0, 1'b0, DIV_LAT);
        run_op("div_5_0",    OP_DIV, 24'h014000, 24'h000000, 24'h7FFFFF, 1'b0, 1'b1, 1);
        run_op("div_300_05", OP_DIV, 24'h4B0000, 24'h002000, 24'h7FFFFF, 1'b1, 1'b0, 1);
        run_op("div_sat_lo", OP_DIV, 24'h400000, 24'h802000, 24'hFFFFFF, 1'b1, 1'b0, 1);

        // Back-pressure: hold an ADD result for 3 cycles, then stream 4 ADDs.
        @(negedge clk);
        bus.out_ready = 1'b0;
        run_op("bp_add", OP_ADD, 24'h004000, 24'h008000, 24'h00C000, 1'b0, 1'b0, 1);
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.a        = s_a[0];
        bus.b        = s_b[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp.hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp.hold_result", 32'(bus.result), 32'h00C000);
            check("bp.hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stream.out_valid", 32'(bus.out_valid), 32'd1);
            check("stream.result", 32'(bus.result), 32'(s_exp[i]));
            if (i < 3) begin
                bus.a = s_a[i+1];
                bus.b = s_b[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("stream.drained", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of a DIV abandons it.
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = OP_DIV;
        bus.a        = 24'h004000;
        bus.b        = 24'h008000;
        repeat (10) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        check("rst.busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.in_ready_after", 32'(bus.in_ready), 32'd1);
        stray = 0;
        repeat (30) begin
            @(negedge clk);
            stray += int'(bus.out_valid);
        end
        check("rst.no_out_valid", 32'(stray), 32'd0);
        run_op("rst_add_1_1", OP_ADD, 24'h004000, 24'h004000, 24'h008000, 1'b0, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/au_hs.md
Name: au_hs

Overview:
- Parametrised, handshaked successor to the Kalman datapath arithmetic unit.
- Operates on sign-magnitude Q(M).FRAC operands, where M = W-1-FRAC.
- ADD, SUB and MUL complete in 1 cycle, registered. DIV uses restoring long division, one quotient bit per cycle.
- All results are saturating with overflow and divide-by-zero flags, and sit behind a valid/ready interface so the Kalman sequencer can back-pressure.

Parameters:
- W, 24, total word width: sign + M integer bits + FRAC fraction bits.
- FRAC, 14, fraction bits. Must satisfy 1 <= FRAC <= W-2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV (a/b).
- a  in  W  operand A, sign-magnitude.
- b  in  W  operand B, sign-magnitude.
- out_valid  out  1  result, ovf and dz are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  sign-magnitude result.
- ovf  out  1  result saturated because magnitude exceeded 2^(W-1)-1.
- dz  out  1  DIV with |b| == 0.
- busy  out  1  DIV iteration in progress.

Behaviour:
- Reset: state IDLE; out_valid, result, ovf, dz and busy all 0. rst during DIV abandons the operation and produces no out_valid.
- States:
  - IDLE: no work pending.
  - DIV: iteration in progress.
  - HOLD: out_valid=1, waiting for out_ready.
- Handshake:
  - in_ready = (state != DIV) && (!out_valid || out_ready).
  - Accept when in_valid && in_ready; a, b and op are captured on acceptance. Later input changes are ignored.
  - Output retire occurs on out_valid && out_ready.
  - Retire and a new acceptance in the same cycle are legal, giving back-to-back throughput of 1 op/cycle for ADD/SUB/MUL.
  - While out_valid && !out_ready: result, ovf and dz are held stable.
- ADD/SUB:
  - SUB negates the sign of b, then performs ADD.
  - Same signs: add magnitudes. Different signs: subtract the smaller magnitude from the larger; sign follows the larger.
  - Carry out of W-1 bits: result = {sign, all ones}, ovf=1.
  - Zero magnitude always yields sign 0 (+0).
  - Latency: out_valid on the cycle after acceptance.
- MUL:
  - Magnitude = (|a|*|b|) >> FRAC, truncated. Sign = a[W-1]^b[W-1].
  - Magnitude >= 2^(W-1): saturate, ovf=1.
  - Zero result gives +0. Latency 1.
- DIV:
  - |b| == 0: result = {a^b sign, all ones}, dz=1, ovf=0, latency 1, no DIV state.
  - Else if |a| >= (|b| << M): saturate, ovf=1, latency 1.
  - Otherwise: quotient = (|a| << FRAC) / |b|, restoring division, W-1 iterations, MSB first. busy=1 for those W-1 cycles, then HOLD.
  - out_valid asserts exactly W cycles after acceptance (24 at default). Truncated; zero gives +0.
- ovf and dz are cleared on every new result.

Optional Feature:
- AU_ROUND_EN defined:
  - MUL adds product bit FRAC-1 before the shift (round half up on magnitude).
  - DIV computes one extra quotient bit and adds it to the LSB. DIV latency becomes W+1 cycles.
  - Rounding carry past the max magnitude saturates with ovf=1.
- Undefined: truncation everywhere; latencies as in Behaviour.

Test Plan:
- ADD 2 + (-3): a=0x008000, b=0x80C000 -> result 0x804000, ovf=0, out_valid 1 cycle after accept. Follow with SUB 5-5 -> 0x000000 (+0).
- MUL 1.5*2.5: a=0x006000, b=0x00A000 -> 0x00F000. Then -1.5*2.5 -> 0x80F000. Then 400*2 -> 0x7FFFFF, ovf=1.
- DIV 1/2: a=0x004000, b=0x008000 -> 0x002000, out_valid exactly 24 cycles after accept. busy=1 and in_ready=0 for 23 cycles. Also -4/2 -> 0x808000.
- DIV 5/0 -> 0x7FFFFF, dz=1, latency 1, busy never asserted. DIV 300/0.5 -> 0x7FFFFF, ovf=1, latency 1.
- Back-pressure: hold out_ready=0 for 3 cycles after an ADD result. result is stable and in_ready=0. Then out_ready=1 with in_valid=1 every cycle: 4 ADDs retire on 4 consecutive cycles.
- Assert rst for 1 cycle at DIV cycle 10 -> next cycle out_valid=0, busy=0, in_ready=1. A following ADD 1+1 -> 0x008000.
